// File: rtl/game_sequencer.sv
// Game controller: IDLE/PLAY/GAME_OVER sequencing, frame-paced snake moves,
// apple respawn pulses, score and speed-level tracking.
module game_sequencer #(
  parameter int FRAMES_INIT      = 8,
  parameter int FRAMES_MIN       = 2,
  parameter int APPLES_PER_LEVEL = 4,
  parameter int GAME_OVER_FRAMES = 120,
  parameter int SCORE_W          = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               up,
  input  logic               down,
  input  logic               left,
  input  logic               right,
  input  logic [1:0]         collision_state,
  output logic [1:0]         game_state,
  output logic               move_tick,
  output logic               apple_trigger,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         level
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PLAY = 2'b01;
  localparam logic [1:0] ST_OVER = 2'b11;

  localparam int CNT_W  = $clog2(FRAMES_INIT + 1);
  localparam int HOLD_W = $clog2(GAME_OVER_FRAMES + 1);
  localparam int APL_W  = $clog2(APPLES_PER_LEVEL + 1);

  localparam logic [CNT_W-1:0]  PERIOD_INIT = CNT_W'(FRAMES_INIT);
  localparam logic [CNT_W-1:0]  PERIOD_MIN  = CNT_W'(FRAMES_MIN);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(GAME_OVER_FRAMES - 32'd1);
  localparam logic [APL_W-1:0]  APPLE_LAST  = APL_W'(APPLES_PER_LEVEL - 32'd1);

  logic [1:0]         state_r, state_s;
  logic [CNT_W-1:0]   frame_cnt_r, frame_cnt_s;
  logic [CNT_W-1:0]   period_r, period_s;
  logic [HOLD_W-1:0]  hold_cnt_r, hold_cnt_s;
  logic [APL_W-1:0]   apple_cnt_r, apple_cnt_s;
  logic [SCORE_W-1:0] score_r, score_s;
  logic [3:0]         level_r, level_s;
  logic               move_r, move_s;
  logic               trig_r, trig_s;
  logic               prev_apple_r;
  logic               any_btn_s;
  logic               apple_evt_s;
  logic               hold_done_s;

  assign any_btn_s   = up | down | left | right;
  assign apple_evt_s = (collision_state == 2'b10) && !prev_apple_r;
  assign hold_done_s = frame_tick && (hold_cnt_r == HOLD_LAST);

  assign game_state    = state_r;
  assign move_tick     = move_r;
  assign apple_trigger = trig_r;
  assign score         = score_r;
  assign level         = level_r;

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      frame_cnt_r  <= {CNT_W{1'b0}};
      period_r     <= PERIOD_INIT;
      hold_cnt_r   <= {HOLD_W{1'b0}};
      apple_cnt_r  <= {APL_W{1'b0}};
      score_r      <= {SCORE_W{1'b0}};
      level_r      <= 4'd0;
      move_r       <= 1'b0;
      trig_r       <= 1'b0;
      prev_apple_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      frame_cnt_r  <= frame_cnt_s;
      period_r     <= period_s;
      hold_cnt_r   <= hold_cnt_s;
      apple_cnt_r  <= apple_cnt_s;
      score_r      <= score_s;
      level_r      <= level_s;
      move_r       <= move_s;
      trig_r       <= trig_s;
      prev_apple_r <= (collision_state == 2'b10);
    end
  end

  // Next-state selection; collision wins over everything in PLAY
  always_comb begin
    state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: if (any_btn_s) state_s = ST_PLAY; else state_s = ST_IDLE;
      ST_PLAY: if (collision_state == 2'b01) state_s = ST_OVER; else state_s = ST_PLAY;
      ST_OVER: if (hold_done_s) state_s = ST_IDLE; else state_s = ST_OVER;
      default: state_s = ST_IDLE;
    endcase
  end

  // Counter, score, level and pulse updates for the coming cycle
  always_comb begin
    frame_cnt_s = frame_cnt_r;
    period_s    = period_r;
    hold_cnt_s  = hold_cnt_r;
    apple_cnt_s = apple_cnt_r;
    score_s     = score_r;
    level_s     = level_r;
    move_s      = 1'b0;
    trig_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_btn_s) begin
          frame_cnt_s = {CNT_W{1'b0}};
          period_s    = PERIOD_INIT;
          apple_cnt_s = {APL_W{1'b0}};
          score_s     = {SCORE_W{1'b0}};
          level_s     = 4'd0;
        end else begin
          score_s = score_r;
        end
      end
      ST_PLAY: begin
        if (collision_state == 2'b01) begin
          hold_cnt_s = {HOLD_W{1'b0}};
        end else begin
          // Compare uses the period in force before any same-cycle level-up
          if (frame_tick) begin
            if (frame_cnt_r >= (period_r - CNT_W'(1'b1))) begin
              move_s      = 1'b1;
              frame_cnt_s = {CNT_W{1'b0}};
            end else begin
              frame_cnt_s = frame_cnt_r + CNT_W'(1'b1);
            end
          end else begin
            frame_cnt_s = frame_cnt_r;
          end
          if (apple_evt_s) begin
            trig_s = 1'b1;
            if (score_r != {SCORE_W{1'b1}}) score_s = score_r + SCORE_W'(1'b1);
            else score_s = score_r;
            if (apple_cnt_r == APPLE_LAST) begin
              apple_cnt_s = {APL_W{1'b0}};
              if (level_r != 4'hF) level_s = level_r + 4'd1;
              else level_s = level_r;
              if (period_r > PERIOD_MIN) period_s = period_r - CNT_W'(1'b1);
              else period_s = period_r;
            end else begin
              apple_cnt_s = apple_cnt_r + APL_W'(1'b1);
            end
          end else begin
            apple_cnt_s = apple_cnt_r;
          end
        end
      end
      ST_OVER: begin
        if (frame_tick) begin
          if (hold_done_s) hold_cnt_s = {HOLD_W{1'b0}};
          else hold_cnt_s = hold_cnt_r + HOLD_W'(1'b1);
        end else begin
          hold_cnt_s = hold_cnt_r;
        end
      end
      default: hold_cnt_s = {HOLD_W{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: an apple-count based reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       reset, frame_tick, up, down, left, right;
  logic [1:0] coll;
  logic [1:0] game_state, game_state2;
  logic       move_tick, move_tick2, apple_trigger, apple_trigger2;
  logic [7:0] score;
  logic [1:0] score2;
  logic [3:0] level, level2;

  int checks = 0;
  int failures = 0;
  int n_moves = 0;
  int n_trig = 0;

  int m_state, m_frames, m_apples, m_hold;
  bit m_prev, e_move, e_trig;

  always #5 clk = ~clk;

  game_sequencer dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .up(up), .down(down), .left(left), .right(right),
    .collision_state(coll), .game_state(game_state), .move_tick(move_tick),
    .apple_trigger(apple_trigger), .score(score), .level(level)
  );

  game_sequencer #(.SCORE_W(2)) dut2 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .up(up), .down(down), .left(left), .right(right),
    .collision_state(coll), .game_state(game_state2), .move_tick(move_tick2),
    .apple_trigger(apple_trigger2), .score(score2), .level(level2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Moves every period frames; period shrinks by one per completed level, floored at 2
  function automatic int m_period();
    return (8 - m_apples / 4 > 2) ? 8 - m_apples / 4 : 2;
  endfunction

  // Reference model stepped on each rising edge, compared 1 time unit later
  always @(posedge clk) begin
    if (!reset) begin
      m_state = 0; m_frames = 0; m_apples = 0; m_hold = 0;
      m_prev = 1'b0; e_move = 1'b0; e_trig = 1'b0;
    end else begin
      e_move = 1'b0;
      e_trig = 1'b0;
      case (m_state)
        0: if (up | down | left | right) begin m_state = 1; m_apples = 0; m_frames = 0; end
        1: begin
          if (coll == 2'b01) begin
            m_state = 3;
            m_hold = 0;
          end else begin
            if (frame_tick) begin
              m_frames++;
              if (m_frames >= m_period()) begin e_move = 1'b1; m_frames = 0; end
            end
            if (coll == 2'b10 && !m_prev) begin e_trig = 1'b1; m_apples++; end
          end
        end
        3: if (frame_tick) begin
          m_hold++;
          if (m_hold == 120) begin m_state = 0; m_hold = 0; end
        end
        default: m_state = 0;
      endcase
      m_prev = (coll == 2'b10);
    end
    #1;
    chk("state", game_state, m_state);
    chk("move_tick", move_tick, e_move);
    chk("apple_trigger", apple_trigger, e_trig);
    chk("score", score, imin(m_apples, 255));
    chk("level", level, imin(m_apples / 4, 15));
    chk("state_w2", game_state2, m_state);
    chk("move_tick_w2", move_tick2, e_move);
    chk("score_w2", score2, imin(m_apples, 3));
    if (move_tick === 1'b1) n_moves++;
    if (apple_trigger === 1'b1) n_trig++;
  end

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
    end
  endtask

  task automatic apple(input int hold_cycles);
    @(negedge clk) coll = 2'b10;
    repeat (hold_cycles) @(negedge clk);
    coll = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; frame_tick = 1'b0; coll = 2'b00;
    up = 1'b1; down = 1'b1; left = 1'b1; right = 1'b1;
    // Reset held with buttons pressed
    repeat (3) @(negedge clk);
    chk("rst_state", game_state, 0);
    chk("rst_score", score, 0);
    chk("rst_level", level, 0);
    chk("rst_move", move_tick, 0);
    chk("rst_trig", apple_trigger, 0);
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", game_state, 0);

    // Start and base move rate
    up = 1'b1;
    @(negedge clk) up = 1'b0;
    chk("start_play", game_state, 1);
    frames(7);
    chk("no_move_7", n_moves, 0);
    frames(1);
    chk("move_at_8", n_moves, 1);
    frames(8);
    chk("move_at_16", n_moves, 2);

    // Apple held for 50 cycles is one event
    apple(50);
    chk("one_trig", n_trig, 1);
    chk("score_1", score, 1);
    for (int i = 0; i < 3; i++) apple(3);
    chk("level_1", level, 1);
    chk("score_4", score, 4);
    frames(6);
    chk("no_move_6_l1", n_moves, 2);
    frames(1);
    chk("move_7_l1", n_moves, 3);
    for (int i = 0; i < 20; i++) apple(2);
    chk("level_6", level, 6);
    chk("score_24", score, 24);
    chk("score_w2_sat", score2, 3);
    frames(1);
    chk("no_move_1_floor", n_moves, 3);
    frames(1);
    chk("move_2_floor", n_moves, 4);

    // Collision on a move-firing tick
    frames(1);
    @(negedge clk) begin frame_tick = 1'b1; coll = 2'b01; end
    @(negedge clk) begin frame_tick = 1'b0; coll = 2'b00; end
    chk("over_state", game_state, 3);
    chk("no_move_collide", n_moves, 4);
    apple(5);
    chk("no_trig_over", n_trig, 24);

    // Game-over hold with a button pressed throughout
    up = 1'b1;
    frames(119);
    chk("hold_119", game_state, 3);
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    chk("back_idle", game_state, 0);
    chk("score_kept", score, 24);
    @(negedge clk);
    chk("restart", game_state, 1);
    chk("score_cleared", score, 0);
    up = 1'b0;

    // Reset on a move-firing tick
    frames(7);
    chk("pre_rst_moves", n_moves, 4);
    @(negedge clk) begin frame_tick = 1'b1; reset = 1'b0; end
    @(negedge clk) begin frame_tick = 1'b0; reset = 1'b1; end
    chk("midgame_rst_state", game_state, 0);
    chk("midgame_rst_move", n_moves, 4);

    // Apple and move in the same cycle are both honoured
    left = 1'b1;
    @(negedge clk) left = 1'b0;
    frames(7);
    @(negedge clk) begin frame_tick = 1'b1; coll = 2'b10; end
    @(negedge clk) begin frame_tick = 1'b0; coll = 2'b00; end
    chk("both_move", n_moves, 5);
    chk("both_trig", n_trig, 25);
    chk("both_score", score, 1);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
